// File: rtl/lsu.sv
// Memory-access stage: single-outstanding data-memory port, load align/extend, store lane/mask build, MEM/WB register.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 exu_valid,
    input  logic                 exu_load_en,
    input  logic                 exu_store_en,
    input  logic [2:0]           exu_funct3,
    input  logic [XLEN-1:0]      exu_alu_result,
    input  logic [XLEN-1:0]      exu_data_rs2,
    input  logic [XLEN-1:0]      exu_snxt_pc,
    input  logic                 exu_wb_alu_en,
    input  logic                 exu_wb_spc_en,
    input  logic                 exu_wb_en,
    input  logic                 exu_ebreak_en,
    input  logic [4:0]           exu_index_rd,
    input  logic [XLEN-1:0]      exu_pc,
    input  logic [31:0]          exu_instr,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [XLEN-1:0]      mem_req_addr,
    output logic [XLEN-1:0]      mem_req_wdata,
    output logic [BUS_BYTES-1:0] mem_req_wmask,
    input  logic                 mem_resp_valid,
    input  logic [XLEN-1:0]      mem_resp_rdata,
    output logic                 lsu_stall,
    output logic                 lsu_wb_en,
    output logic [XLEN-1:0]      lsu_wb_data,
    output logic [4:0]           lsu_index_rd,
    output logic [XLEN-1:0]      lsu_pc,
    output logic [31:0]          lsu_instr,
    output logic                 lsu_valid,
    output logic                 lsu_ebreak_en,
    output logic                 lsu_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      off;
    logic [7:0]      size_mask;
    logic [2:0]      align_mask;
    logic            misalign;
    logic            mem_op;
    logic            req_valid;
    logic            stall;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_data_d;
    logic            unused_wb_alu;

    // writeback select falls through to alu_result, so the ALU select flag carries no extra information
    assign unused_wb_alu = exu_wb_alu_en;

    assign off = exu_alu_result[2:0];

    always_comb begin
        size_mask  = 8'h01;
        align_mask = 3'b000;
        case (exu_funct3[1:0])
            2'd0: begin size_mask = 8'h01; align_mask = 3'b000; end
            2'd1: begin size_mask = 8'h03; align_mask = 3'b001; end
            2'd2: begin size_mask = 8'h0F; align_mask = 3'b011; end
            default: begin size_mask = 8'hFF; align_mask = 3'b111; end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = exu_valid & (exu_load_en | exu_store_en) & (|(off & align_mask));
`else
    logic unused_align;
    assign unused_align = |align_mask;
    assign misalign     = 1'b0;
`endif

    assign mem_op = exu_valid & (exu_load_en | exu_store_en) & ~misalign;

    always_ff @(posedge clk) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    req_valid = 1'b1;
                    stall     = 1'b1;
                    state_d   = mem_req_ready ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (mem_req_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                stall = ~mem_resp_valid;
                if (mem_resp_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // request fields are forced low while in reset so nothing leaks onto the bus
    assign mem_req_valid = rstn & req_valid;
    assign mem_req_we    = rstn & exu_store_en;
    assign mem_req_addr  = rstn ? {exu_alu_result[XLEN-1:3], 3'b000} : '0;
    assign mem_req_wdata = rstn ? (exu_data_rs2 << {off, 3'b000}) : '0;
    assign mem_req_wmask = rstn ? (size_mask << off) : '0;
    assign lsu_stall     = rstn & stall;

    assign sh = mem_resp_rdata >> {off, 3'b000};

    always_comb begin
        load_val = '0;
        case (exu_funct3)
            3'b000:  load_val = {{56{sh[7]}},  sh[7:0]};
            3'b001:  load_val = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_val = {{32{sh[31]}}, sh[31:0]};
            3'b011:  load_val = sh;
            3'b100:  load_val = {56'd0, sh[7:0]};
            3'b101:  load_val = {48'd0, sh[15:0]};
            3'b110:  load_val = {32'd0, sh[31:0]};
            default: load_val = '0;
        endcase
    end

    assign wb_data_d = exu_load_en   ? load_val    :
                       exu_wb_spc_en ? exu_snxt_pc : exu_alu_result;

    always_ff @(posedge clk) begin
        if (!rstn || stall) begin
            lsu_wb_en     <= 1'b0;
            lsu_wb_data   <= '0;
            lsu_index_rd  <= '0;
            lsu_pc        <= '0;
            lsu_instr     <= '0;
            lsu_valid     <= 1'b0;
            lsu_ebreak_en <= 1'b0;
            lsu_misalign  <= 1'b0;
        end else begin
            lsu_wb_en     <= exu_wb_en & exu_valid & ~misalign;
            lsu_wb_data   <= wb_data_d;
            lsu_index_rd  <= exu_index_rd;
            lsu_pc        <= exu_pc;
            lsu_instr     <= exu_instr;
            lsu_valid     <= exu_valid;
            lsu_ebreak_en <= exu_ebreak_en;
            lsu_misalign  <= misalign;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random instruction stream against a byte-level model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        exu_valid, exu_load_en, exu_store_en;
    logic [2:0]  exu_funct3;
    logic [63:0] exu_alu_result, exu_data_rs2, exu_snxt_pc, exu_pc;
    logic        exu_wb_alu_en, exu_wb_spc_en, exu_wb_en, exu_ebreak_en;
    logic [4:0]  exu_index_rd;
    logic [31:0] exu_instr;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        lsu_stall, lsu_wb_en, lsu_valid, lsu_ebreak_en, lsu_misalign;
    logic [63:0] lsu_wb_data, lsu_pc;
    logic [4:0]  lsu_index_rd;
    logic [31:0] lsu_instr;

    lsu #(.XLEN(64), .BUS_BYTES(8)) dut (
        .clk(clk), .rstn(rstn),
        .exu_valid(exu_valid), .exu_load_en(exu_load_en), .exu_store_en(exu_store_en),
        .exu_funct3(exu_funct3), .exu_alu_result(exu_alu_result), .exu_data_rs2(exu_data_rs2),
        .exu_snxt_pc(exu_snxt_pc), .exu_wb_alu_en(exu_wb_alu_en), .exu_wb_spc_en(exu_wb_spc_en),
        .exu_wb_en(exu_wb_en), .exu_ebreak_en(exu_ebreak_en), .exu_index_rd(exu_index_rd),
        .exu_pc(exu_pc), .exu_instr(exu_instr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .lsu_stall(lsu_stall), .lsu_wb_en(lsu_wb_en), .lsu_wb_data(lsu_wb_data),
        .lsu_index_rd(lsu_index_rd), .lsu_pc(lsu_pc), .lsu_instr(lsu_instr),
        .lsu_valid(lsu_valid), .lsu_ebreak_en(lsu_ebreak_en), .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, load, store, wb_alu, wb_spc, wb_en, ebreak;
        logic [2:0]  f3;
        logic [63:0] alu, rs2, snpc, pc, rdata;
        logic [4:0]  rd;
        logic [31:0] instr;
        int unsigned rdy_dly, lat;
    } op_t;

    op_t         prog[$];
    int unsigned n_checks = 0, n_fail = 0;
    bit          accepted = 0;
    int unsigned since = 0, wcnt = 0;
    int unsigned n_stall = 0, n_req = 0;
    logic [63:0] last_addr, last_wdata;
    logic [7:0]  last_mask;
    logic        exp_valid, exp_wb_en, exp_ebreak, exp_mis;
    logic [63:0] exp_data, exp_pc;
    logic [4:0]  exp_rd;
    logic [31:0] exp_instr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t idle_op();
        op_t o;
        o.valid = 0; o.load = 0; o.store = 0; o.wb_alu = 0; o.wb_spc = 0; o.wb_en = 0; o.ebreak = 0;
        o.f3 = 0; o.alu = 0; o.rs2 = 0; o.snpc = 0; o.pc = 0; o.rdata = 0; o.rd = 0; o.instr = 0;
        o.rdy_dly = 0; o.lat = 1;
        return o;
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // load: gather size bytes starting at the byte offset (bytes beyond the dword read as 0), then extend
    function automatic logic [63:0] ld_model(input logic [63:0] rdata, input logic [63:0] addr, input logic [2:0] f3);
        int unsigned off = int'(addr[2:0]);
        int unsigned nb = nbytes(f3);
        logic [63:0] v = '0;
        if (f3 == 3'b111) return '0;
        for (int unsigned i = 0; i < nb; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int unsigned i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] st_data(input logic [63:0] rs2, input logic [63:0] addr);
        int unsigned off = int'(addr[2:0]);
        logic [63:0] w = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (i >= off) w[8*i +: 8] = rs2[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic logic [7:0] st_mask(input logic [63:0] addr, input logic [2:0] f3);
        int unsigned off = int'(addr[2:0]);
        logic [7:0] m = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (i >= off && i - off < nbytes(f3)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit is_mis(input logic [63:0] addr, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(addr[2:0]) % nbytes(f3)) != 0;
`else
        return (addr[0] & 1'b0) != 1'b0;
`endif
    endfunction

    task automatic drive(input op_t o);
        exu_valid = o.valid; exu_load_en = o.load; exu_store_en = o.store; exu_funct3 = o.f3;
        exu_alu_result = o.alu; exu_data_rs2 = o.rs2; exu_snxt_pc = o.snpc; exu_pc = o.pc;
        exu_wb_alu_en = o.wb_alu; exu_wb_spc_en = o.wb_spc; exu_wb_en = o.wb_en;
        exu_ebreak_en = o.ebreak; exu_index_rd = o.rd; exu_instr = o.instr;
    endtask

    task automatic clear_exp();
        exp_valid = 0; exp_wb_en = 0; exp_ebreak = 0; exp_mis = 0;
        exp_data = '0; exp_pc = '0; exp_rd = '0; exp_instr = '0;
    endtask

    // one clock: entered and left at posedge+1; the bench acts as the EX/MEM register and the memory
    task automatic run_cycle();
        op_t cur;
        bit mis, memop, rdy, rv, exp_req, exp_stall;
        logic [63:0] rd_v;
        check("lsu_valid", lsu_valid, exp_valid);
        check("lsu_wb_en", lsu_wb_en, exp_wb_en);
        check("lsu_wb_data", lsu_wb_data, exp_data);
        check("lsu_index_rd", lsu_index_rd, exp_rd);
        check("lsu_pc", lsu_pc, exp_pc);
        check("lsu_instr", lsu_instr, exp_instr);
        check("lsu_ebreak_en", lsu_ebreak_en, exp_ebreak);
        check("lsu_misalign", lsu_misalign, exp_mis);
        cur = (prog.size() != 0) ? prog[0] : idle_op();
        mis = cur.valid && (cur.load || cur.store) && is_mis(cur.alu, cur.f3);
        memop = cur.valid && (cur.load || cur.store) && !mis;
        rdy = (memop && !accepted) ? (wcnt >= cur.rdy_dly) : 1'($urandom_range(0, 1));
        rv = 0;
        rd_v = {$urandom, $urandom};
        if (memop && accepted && since == cur.lat) begin
            rv = 1;
            rd_v = cur.rdata;
        end else if (!(memop && accepted)) begin
            rv = ($urandom_range(0, 3) == 0);
        end
        drive(cur);
        mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_rdata = rd_v;
        #1;
        exp_req = memop && !accepted;
        exp_stall = memop && !(accepted && rv);
        check("mem_req_valid", mem_req_valid, exp_req);
        check("lsu_stall", lsu_stall, exp_stall);
        if (exp_req) begin
            check("mem_req_we", mem_req_we, cur.store);
            check("mem_req_addr", mem_req_addr, {cur.alu[63:3], 3'b000});
            check("mem_req_wmask", mem_req_wmask, st_mask(cur.alu, cur.f3));
            check("mem_req_wdata", mem_req_wdata, st_data(cur.rs2, cur.alu));
            last_addr = mem_req_addr; last_mask = mem_req_wmask; last_wdata = mem_req_wdata;
        end
        if (mem_req_valid && mem_req_ready) n_req++;
        if (lsu_stall) n_stall++;
        if (exp_stall) begin
            clear_exp();
        end else begin
            exp_valid = cur.valid;
            exp_wb_en = cur.wb_en && cur.valid && !mis;
            exp_data = cur.load ? ld_model(rd_v, cur.alu, cur.f3) : (cur.wb_spc ? cur.snpc : cur.alu);
            exp_rd = cur.rd; exp_pc = cur.pc; exp_instr = cur.instr;
            exp_ebreak = cur.ebreak; exp_mis = mis;
        end
        @(posedge clk);
        #1;
        if (exp_req && rdy) begin
            accepted = 1; since = 1;
        end else if (accepted) begin
            since++;
        end
        if (exp_req && !rdy) wcnt++;
        if (!exp_stall) begin
            if (prog.size() != 0) void'(prog.pop_front());
            accepted = 0; since = 0; wcnt = 0;
        end
    endtask

    task automatic run_queue(input int unsigned budget);
        int unsigned g = 0;
        n_stall = 0; n_req = 0;
        while (prog.size() != 0 && g < budget) begin
            run_cycle();
            g++;
        end
        if (prog.size() != 0) begin
            check("drain_timeout", 64'(prog.size()), 64'd0);
            prog.delete();
            accepted = 0; since = 0; wcnt = 0;
        end
    endtask

    function automatic op_t mk(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] alu);
        op_t o = idle_op();
        o.valid = 1; o.load = ld; o.store = st; o.f3 = f3; o.alu = alu;
        o.wb_en = ld; o.pc = 64'h8000_0100; o.snpc = 64'h8000_0104; o.instr = 32'h0000_0013;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o = idle_op();
        int unsigned k = $urandom_range(0, 99);
        o.valid = 1;
        o.pc = {$urandom, $urandom}; o.snpc = o.pc + 64'd4; o.instr = $urandom;
        o.rd = 5'($urandom_range(0, 31)); o.ebreak = ($urandom_range(0, 15) == 0);
        o.alu = {$urandom, $urandom}; o.rs2 = {$urandom, $urandom}; o.rdata = {$urandom, $urandom};
        o.rdy_dly = $urandom_range(0, 3); o.lat = $urandom_range(1, 4);
        o.wb_en = 1'($urandom_range(0, 1));
        if (k < 35) begin
            o.wb_alu = 1;
        end else if (k < 45) begin
            o.wb_spc = 1;
        end else if (k < 70) begin
            o.load = 1; o.f3 = 3'($urandom_range(0, 7));
        end else if (k < 92) begin
            o.store = 1; o.f3 = 3'($urandom_range(0, 3)); o.wb_en = 0;
        end else begin
            o.valid = 0; o.wb_en = 0; o.alu = 0; o.rs2 = 0; o.rdata = 0;
        end
        if ((o.load || o.store) && $urandom_range(0, 1) == 1)
            o.alu[2:0] = o.alu[2:0] & ~3'(nbytes(o.f3) - 1);
        return o;
    endfunction

    initial begin
        op_t o, o2;
        int unsigned g;
        // reset with a load already presented: no request may escape
        o = mk(1, 0, 3'b011, 64'h40);
        drive(o);
        mem_req_ready = 1; mem_resp_valid = 0; mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_lsu_valid", lsu_valid, 0);
        check("rst_wb_data", lsu_wb_data, 0);
        drive(idle_op());
        rstn = 1;
        clear_exp();

        // ALU writeback
        o = mk(0, 0, 3'b000, 64'h1234); o.wb_alu = 1; o.wb_en = 1; o.rd = 5;
        prog.push_back(o); run_queue(10);
        check("alu_wb_data", lsu_wb_data, 64'h1234);
        check("alu_rd", lsu_index_rd, 5);
        check("alu_no_stall", n_stall, 0);

        // LB, immediate accept, response after 3 cycles
        o = mk(1, 0, 3'b000, 64'h8000_0003); o.rdata = 64'h0000_0000_80FF_0000; o.lat = 3;
        prog.push_back(o); run_queue(20);
        check("lb_addr", last_addr, 64'h8000_0000);
        check("lb_stall_cycles", n_stall, 3);
        check("lb_wb_data", lsu_wb_data, 64'hFFFF_FFFF_FFFF_FF80);

        // SH with ready held low 3 cycles
        o = mk(0, 1, 3'b001, 64'h1006); o.rs2 = 64'hABCD; o.rdy_dly = 3; o.lat = 2; o.wb_en = 0;
        prog.push_back(o); run_queue(20);
        check("sh_wmask", last_mask, 8'hC0);
        check("sh_wdata", last_wdata, 64'hABCD_0000_0000_0000);
        check("sh_wb_en", lsu_wb_en, 0);
        check("sh_one_req", n_req, 1);

        // LWU followed back-to-back by LD
        o = mk(1, 0, 3'b110, 64'h1004); o.rdata = 64'h8000_0001_1234_5678; o.lat = 1;
        o2 = mk(1, 0, 3'b011, 64'h2000); o2.rdata = 64'h0123_4567_89AB_CDEF; o2.lat = 2;
        prog.push_back(o); prog.push_back(o2); run_queue(30);
        check("ld_pair_reqs", n_req, 2);
        check("ld_wb_data", lsu_wb_data, 64'h0123_4567_89AB_CDEF);
        o = mk(1, 0, 3'b110, 64'h1004); o.rdata = 64'h8000_0001_1234_5678; o.lat = 1;
        prog.push_back(o); run_queue(20);
        check("lwu_wb_data", lsu_wb_data, 64'h0000_0000_8000_0001);

        // jal writes snxt_pc
        o = mk(0, 0, 3'b000, 64'h5555); o.wb_spc = 1; o.wb_en = 1; o.snpc = 64'h8000_0010;
        prog.push_back(o); run_queue(10);
        check("jal_wb_data", lsu_wb_data, 64'h8000_0010);

        // reset while waiting for a response, then a late response
        o = mk(1, 0, 3'b011, 64'h3000); o.lat = 20;
        prog.push_back(o);
        g = 0;
        while (!(accepted && since >= 2) && g < 10) begin
            run_cycle();
            g++;
        end
        check("reached_wait", 64'(accepted), 1);
        rstn = 0; drive(idle_op()); mem_req_ready = 0; mem_resp_valid = 0;
        @(posedge clk);
        #1;
        rstn = 1;
        prog.delete(); accepted = 0; since = 0; wcnt = 0;
        check("rstw_lsu_valid", lsu_valid, 0);
        check("rstw_wb_data", lsu_wb_data, 0);
        #1;
        check("rstw_stall_idle", lsu_stall, 0);
        check("rstw_req_valid", mem_req_valid, 0);
        @(posedge clk);
        #1;
        mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("late_resp_stall", lsu_stall, 0);
        @(posedge clk);
        #1;
        clear_exp();
        o = mk(1, 0, 3'b010, 64'h4000); o.rdata = 64'h0000_0000_FFFF_FFFE; o.lat = 2;
        prog.push_back(o); run_queue(20);
        check("post_rst_reqs", n_req, 1);
        check("post_rst_lw", lsu_wb_data, 64'hFFFF_FFFF_FFFF_FFFE);

        // misaligned LW
        o = mk(1, 0, 3'b010, 64'h1002); o.rdata = 64'h0; o.lat = 1;
        prog.push_back(o); run_queue(20);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_no_req", n_req, 0);
        check("mis_flag", lsu_misalign, 1);
        check("mis_wb_en", lsu_wb_en, 0);
`else
        check("mis_req_issued", n_req, 1);
        check("mis_flag_tied", lsu_misalign, 0);
`endif

        // random instruction stream
        for (int i = 0; i < 400; i++) prog.push_back(rand_op());
        run_queue(20000);
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
